// File: rtl/sat_mem_pkg.sv
// -----------------------------------------------------------------------------
// sat_mem_pkg
// Shared definitions for the clause-store write path: loader FSM states,
// loader error codes, default capacities with their derived address widths,
// and the 33-bit literal magnitude helper.
// -----------------------------------------------------------------------------
package sat_mem_pkg;

    localparam int unsigned DEF_MAX_VARS    = 256;
    localparam int unsigned DEF_MAX_CLAUSES = 2560;
    localparam int unsigned DEF_MAX_LITS    = 10240;

    localparam int unsigned DEF_LIT_AW = $clog2(DEF_MAX_LITS);
    localparam int unsigned DEF_CLS_AW = $clog2(DEF_MAX_CLAUSES);
    localparam int unsigned DEF_VAR_W  = $clog2(DEF_MAX_VARS) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } loader_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_BAD_VAR = 2'd1,
        ERR_LIT_OVF = 2'd2,
        ERR_CLS_OVF = 2'd3
    } loader_err_t;

    // Magnitude is taken one bit wider than the literal so that -2^31 yields
    // +2^31 (and is then rejected as out of range) instead of wrapping.
    function automatic logic [32:0] lit_abs33(input logic [31:0] lit);
        logic [32:0] ext;
        ext = {lit[31], lit};
        return ext[32] ? (~ext + 33'd1) : ext;
    endfunction

endpackage

// File: rtl/clause_loader_if.sv
// -----------------------------------------------------------------------------
// clause_loader_if
// Literal stream into the clause loader (valid/ready handshake).
//   in_valid : beat valid              (master -> slave)
//   in_ready : loader accepts the beat (slave  -> master)
//   in_lit   : signed literal, 0 ends a clause
//   in_last  : final beat of the formula
// -----------------------------------------------------------------------------
interface clause_loader_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_lit;
    logic        in_last;

    modport master (output in_valid, output in_lit, output in_last, input  in_ready);
    modport slave  (input  in_valid, input  in_lit, input  in_last, output in_ready);

endinterface

// File: rtl/clause_loader.sv
// -----------------------------------------------------------------------------
// clause_loader
// Write-side front end of the clause store. Consumes a DIMACS-ordered literal
// stream and writes literals into lit_mem plus one {start, len} header per
// non-empty clause. Reports counts on completion and flags range/capacity
// errors.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : one-cycle pulse, clears counters and begins a load
//   s_in              : literal stream (clause_loader_if.slave)
//   lit_we/addr/wdata : literal memory write port
//   cls_we/addr/start/len : clause header write port
//   done, error, err_code : completion / abort status (levels)
//   num_clauses, num_lits, max_var : load statistics
// All outputs are registered; a beat accepted at edge N writes in cycle N+1.
// -----------------------------------------------------------------------------
module clause_loader
    import sat_mem_pkg::*;
#(
    parameter int unsigned MAX_VARS    = DEF_MAX_VARS,
    parameter int unsigned MAX_CLAUSES = DEF_MAX_CLAUSES,
    parameter int unsigned MAX_LITS    = DEF_MAX_LITS
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    clause_loader_if.slave                     s_in,
    output logic                               lit_we,
    output logic [$clog2(MAX_LITS)-1:0]        lit_addr,
    output logic [31:0]                        lit_wdata,
    output logic                               cls_we,
    output logic [$clog2(MAX_CLAUSES)-1:0]     cls_addr,
    output logic [15:0]                        cls_start,
    output logic [15:0]                        cls_len,
    output logic                               done,
    output logic                               error,
    output logic [1:0]                         err_code,
    output logic [$clog2(MAX_CLAUSES):0]       num_clauses,
    output logic [$clog2(MAX_LITS):0]          num_lits,
    output logic [$clog2(MAX_VARS):0]          max_var
);

    localparam int unsigned LIT_AW = $clog2(MAX_LITS);
    localparam int unsigned CLS_AW = $clog2(MAX_CLAUSES);
    localparam int unsigned LIT_CW = LIT_AW + 1;
    localparam int unsigned CLS_CW = CLS_AW + 1;
    localparam int unsigned VAR_W  = $clog2(MAX_VARS) + 1;

    localparam logic [LIT_CW-1:0] LIT_CAP = LIT_CW'(MAX_LITS);
    localparam logic [CLS_CW-1:0] CLS_CAP = CLS_CW'(MAX_CLAUSES);
    localparam logic [32:0]       VAR_CAP = 33'(MAX_VARS);

    loader_state_t     r_state;
    loader_err_t       r_err_code;
    logic              r_in_ready;
    logic [LIT_CW-1:0] r_lit_ptr;
    logic [CLS_CW-1:0] r_cls_ptr;
    logic [LIT_CW-1:0] r_cur_start;
    logic [LIT_CW-1:0] r_cur_len;
    logic [VAR_W-1:0]  r_max_var;
    logic              r_done;
    logic              r_error;

    logic              r_lit_we;
    logic [LIT_AW-1:0] r_lit_addr;
    logic [31:0]       r_lit_wdata;
    logic              r_cls_we;
    logic [CLS_AW-1:0] r_cls_addr;
    logic [15:0]       r_cls_start;
    logic [15:0]       r_cls_len;

    logic              w_accept;
    logic              w_nonzero;
    logic [32:0]       w_abs;
    logic              w_do_lit;
    logic              w_do_cls;
    logic              w_fail;
    loader_err_t       w_fail_code;
    logic [LIT_CW-1:0] w_hdr_len;
    logic [LIT_CW-1:0] w_lit_ptr_nxt;

    assign w_accept  = s_in.in_valid & r_in_ready;
    assign w_nonzero = (s_in.in_lit != '0);
    assign w_abs     = lit_abs33(s_in.in_lit);

    // All capacity checks for a beat are resolved before any write is issued,
    // so a last-beat literal whose implicit clause close would overflow the
    // header store produces neither write.
    always_comb begin
        w_do_lit    = 1'b0;
        w_do_cls    = 1'b0;
        w_fail      = 1'b0;
        w_fail_code = ERR_NONE;
        w_hdr_len   = r_cur_len;
        if (w_accept) begin
            if (w_nonzero) begin
                if (w_abs > VAR_CAP) begin
                    w_fail      = 1'b1;
                    w_fail_code = ERR_BAD_VAR;
                end else if (r_lit_ptr == LIT_CAP) begin
                    w_fail      = 1'b1;
                    w_fail_code = ERR_LIT_OVF;
                end else if (s_in.in_last && (r_cls_ptr == CLS_CAP)) begin
                    w_fail      = 1'b1;
                    w_fail_code = ERR_CLS_OVF;
                end else begin
                    w_do_lit  = 1'b1;
                    w_do_cls  = s_in.in_last;
                    w_hdr_len = r_cur_len + LIT_CW'(1);
                end
            end else if (r_cur_len != '0) begin
                if (r_cls_ptr == CLS_CAP) begin
                    w_fail      = 1'b1;
                    w_fail_code = ERR_CLS_OVF;
                end else begin
                    w_do_cls = 1'b1;
                end
            end
        end
    end

    assign w_lit_ptr_nxt = r_lit_ptr + (w_do_lit ? LIT_CW'(1) : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_err_code  <= ERR_NONE;
            r_in_ready  <= 1'b0;
            r_lit_ptr   <= '0;
            r_cls_ptr   <= '0;
            r_cur_start <= '0;
            r_cur_len   <= '0;
            r_max_var   <= '0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_lit_we    <= 1'b0;
            r_lit_addr  <= '0;
            r_lit_wdata <= '0;
            r_cls_we    <= 1'b0;
            r_cls_addr  <= '0;
            r_cls_start <= '0;
            r_cls_len   <= '0;
        end else begin
            r_lit_we <= w_do_lit;
            r_cls_we <= w_do_cls;

            if (w_do_lit) begin
                r_lit_addr  <= r_lit_ptr[LIT_AW-1:0];
                r_lit_wdata <= s_in.in_lit;
                r_lit_ptr   <= w_lit_ptr_nxt;
                r_cur_len   <= r_cur_len + LIT_CW'(1);
                if (w_abs[VAR_W-1:0] > r_max_var) begin
                    r_max_var <= w_abs[VAR_W-1:0];
                end
            end

            // Header close takes priority over the length increment above:
            // the next clause starts right after this beat's literal.
            if (w_do_cls) begin
                r_cls_addr  <= r_cls_ptr[CLS_AW-1:0];
                r_cls_start <= 16'(r_cur_start);
                r_cls_len   <= 16'(w_hdr_len);
                r_cls_ptr   <= r_cls_ptr + CLS_CW'(1);
                r_cur_start <= w_lit_ptr_nxt;
                r_cur_len   <= '0;
            end

            case (r_state)
                ST_LOAD: begin
                    if (w_fail) begin
                        r_state    <= ST_ERROR;
                        r_err_code <= w_fail_code;
                        r_error    <= 1'b1;
                        r_in_ready <= 1'b0;
                    end else if (w_accept && s_in.in_last) begin
                        r_state    <= ST_DONE;
                        r_done     <= 1'b1;
                        r_in_ready <= 1'b0;
                    end
                end
                default: begin
                    if (start) begin
                        r_state     <= ST_LOAD;
                        r_in_ready  <= 1'b1;
                        r_err_code  <= ERR_NONE;
                        r_lit_ptr   <= '0;
                        r_cls_ptr   <= '0;
                        r_cur_start <= '0;
                        r_cur_len   <= '0;
                        r_max_var   <= '0;
                        r_done      <= 1'b0;
                        r_error     <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign s_in.in_ready = r_in_ready;
    assign lit_we        = r_lit_we;
    assign lit_addr      = r_lit_addr;
    assign lit_wdata     = r_lit_wdata;
    assign cls_we        = r_cls_we;
    assign cls_addr      = r_cls_addr;
    assign cls_start     = r_cls_start;
    assign cls_len       = r_cls_len;
    assign done          = r_done;
    assign error         = r_error;
    assign err_code      = r_err_code;
    assign num_clauses   = r_cls_ptr;
    assign num_lits      = r_lit_ptr;
    assign max_var       = r_max_var;

endmodule

// File: tb/tb_clause_loader.sv
// -----------------------------------------------------------------------------
// tb_clause_loader
// Scoreboard bench for clause_loader. The driver pushes the expected write
// record for every beat it presents (from a reference model of the loading
// rules); a negedge monitor pops and compares whenever a write strobe is seen.
// -----------------------------------------------------------------------------
module tb_clause_loader;

    localparam int MAXV = 256;
    localparam int MAXL = 12;
    localparam int MAXC = 5;
    localparam int LAW  = $clog2(MAXL);
    localparam int CAW  = $clog2(MAXC);
    localparam int VW   = $clog2(MAXV) + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;

    always #5 clk = ~clk;

    clause_loader_if bus();

    logic           lit_we;
    logic [LAW-1:0] lit_addr;
    logic [31:0]    lit_wdata;
    logic           cls_we;
    logic [CAW-1:0] cls_addr;
    logic [15:0]    cls_start;
    logic [15:0]    cls_len;
    logic           done;
    logic           error;
    logic [1:0]     err_code;
    logic [CAW:0]   num_clauses;
    logic [LAW:0]   num_lits;
    logic [VW-1:0]  max_var;

    clause_loader #(
        .MAX_VARS    (MAXV),
        .MAX_CLAUSES (MAXC),
        .MAX_LITS    (MAXL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .s_in        (bus),
        .lit_we      (lit_we),
        .lit_addr    (lit_addr),
        .lit_wdata   (lit_wdata),
        .cls_we      (cls_we),
        .cls_addr    (cls_addr),
        .cls_start   (cls_start),
        .cls_len     (cls_len),
        .done        (done),
        .error       (error),
        .err_code    (err_code),
        .num_clauses (num_clauses),
        .num_lits    (num_lits),
        .max_var     (max_var)
    );

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        bit          lw;
        int          laddr;
        logic [31:0] ldata;
        bit          cw;
        int          caddr;
        int          cstart;
        int          clen;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [31:0] img [16];
    logic [31:0] img0[16];

    // Reference model state: literals stored, clauses stored, open clause.
    int m_lp, m_cp, m_cs, m_cl, m_max, m_err;
    bit m_done, m_error, m_load;

    task automatic model_clear(input bit loading);
        m_lp = 0; m_cp = 0; m_cs = 0; m_cl = 0; m_max = 0; m_err = 0;
        m_done = 0; m_error = 0; m_load = loading;
    endtask

    task automatic model_fail(input int code);
        m_err = code; m_error = 1; m_load = 0;
    endtask

    task automatic model_beat(input logic [31:0] lit, input bit last, input int at, output bit term);
        longint v, a;
        bit     closes;
        wr_t    r;
        v = longint'($signed(lit));
        a = (v < 0) ? -v : v;
        closes = ((v == 0) || last) && ((m_cl + ((v != 0) ? 1 : 0)) > 0);
        term = 1;
        if (v != 0 && a > MAXV)    begin model_fail(1); return; end
        if (v != 0 && m_lp == MAXL) begin model_fail(2); return; end
        if (closes && m_cp == MAXC) begin model_fail(3); return; end
        r = '{cyc: at, lw: 0, laddr: 0, ldata: '0, cw: 0, caddr: 0, cstart: 0, clen: 0};
        if (v != 0) begin
            r.lw = 1; r.laddr = m_lp; r.ldata = lit;
            m_lp++; m_cl++;
            if (a > m_max) m_max = int'(a);
        end
        if (closes) begin
            r.cw = 1; r.caddr = m_cp; r.cstart = m_cs; r.clen = m_cl;
            m_cp++; m_cs = m_lp; m_cl = 0;
        end
        if (r.lw || r.cw) exp_q.push_back(r);
        if (last) begin m_done = 1; m_load = 0; end
        term = last;
    endtask

    // Write-port monitor
    always @(negedge clk) begin
        if (rst_n && (lit_we || cls_we)) begin
            if (lit_we) img[lit_addr] = lit_wdata;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL write_unexpected: cyc=%0d lit_we=%0b cls_we=%0b, required no write",
                         cyc, lit_we, cls_we);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.cyc != cyc || mon_e.lw != lit_we || mon_e.cw != cls_we ||
                    (mon_e.lw && (int'(lit_addr) != mon_e.laddr || lit_wdata != mon_e.ldata)) ||
                    (mon_e.cw && (int'(cls_addr) != mon_e.caddr || int'(cls_start) != mon_e.cstart ||
                                  int'(cls_len) != mon_e.clen))) begin
                    miscompares++;
                    $display("FAIL write_port: got cyc=%0d lit(we=%0b a=%0d d=%0d) cls(we=%0b a=%0d s=%0d l=%0d), required cyc=%0d lit(we=%0b a=%0d d=%0d) cls(we=%0b a=%0d s=%0d l=%0d)",
                             cyc, lit_we, lit_addr, $signed(lit_wdata), cls_we, cls_addr, cls_start, cls_len,
                             mon_e.cyc, mon_e.lw, mon_e.laddr, $signed(mon_e.ldata), mon_e.cw, mon_e.caddr,
                             mon_e.cstart, mon_e.clen);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_done"},        64'(done),        64'(m_done));
        chk({tag, "_error"},       64'(error),       64'(m_error));
        chk({tag, "_err_code"},    64'(err_code),    64'(m_err));
        chk({tag, "_num_clauses"}, 64'(num_clauses), 64'(m_cp));
        chk({tag, "_num_lits"},    64'(num_lits),    64'(m_lp));
        chk({tag, "_max_var"},     64'(max_var),     64'(m_max));
        chk({tag, "_in_ready"},    64'(bus.in_ready), 64'(m_load));
        chk({tag, "_pending"},     64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_start(input bit with_valid);
        @(negedge clk);
        start        = 1'b1;
        bus.in_valid = with_valid;
        bus.in_lit   = 32'd9;
        bus.in_last  = 1'b0;
        @(negedge clk);
        start        = 1'b0;
        bus.in_valid = 1'b0;
        model_clear(1);
        #1;
        check_status("start");
    endtask

    task automatic send_beat(input logic [31:0] lit, input bit last, input int gap, output bit term);
        int n;
        repeat (gap) @(negedge clk);
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: got in_ready=0 for %0d cycles, required 1", n);
            term = 1;
            return;
        end
        bus.in_valid = 1'b1;
        bus.in_lit   = lit;
        bus.in_last  = last;
        model_beat(lit, last, cyc + 1, term);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic run_stream(input string tag, input int lits[$], input int max_gap);
        bit term;
        int g;
        term = 0;
        for (int i = 0; i < lits.size() && !term; i++) begin
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            send_beat(lits[i], i == lits.size() - 1, g, term);
        end
        #1;
        check_status(tag);
        // Beats offered after the terminal beat must be ignored.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_lit   = 32'd1;
        bus.in_last  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk({tag, "_ready_after_end"}, 64'(bus.in_ready), 64'd0);
        chk({tag, "_pending_after_end"}, 64'(exp_q.size()), 64'd0);
        bus.in_valid = 1'b0;
    endtask

    task automatic clear_img();
        for (int i = 0; i < 16; i++) img[i] = '0;
    endtask

    task automatic rand_stream(output int s[$]);
        int n, p, sg;
        s.delete();
        n = int'($urandom_range(30, 4));
        for (int k = 0; k < n; k++) begin
            p  = int'($urandom_range(99, 0));
            sg = ($urandom_range(1, 0) == 1) ? 1 : -1;
            if (p < 25)      s.push_back(0);
            else if (p < 29) s.push_back(sg * int'($urandom_range(300, MAXV + 1)));
            else             s.push_back(sg * int'($urandom_range(MAXV, 1)));
        end
    endtask

    int   s[$];
    logic any_out;

    initial begin
        bus.in_valid = 1'b0;
        bus.in_lit   = '0;
        bus.in_last  = 1'b0;
        model_clear(0);
        clear_img();

        #2 rst_n = 1'b0;
        #1;
        any_out = |{lit_we, lit_addr, lit_wdata, cls_we, cls_addr, cls_start, cls_len, done, error,
                    err_code, num_clauses, num_lits, max_var, bus.in_ready};
        chk("reset_outputs", 64'(any_out), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1 chk("idle_ready", 64'(bus.in_ready), 64'd0);

        // start coincident with a valid beat: the beat must not be taken
        do_start(1);
        s = '{1, -2, 0, 3, 0, -1, 2, -3, 0};
        run_stream("basic", s, 0);

        do_start(0);
        s = '{0, 0, 5, 0, 7};
        run_stream("empty_implicit", s, 0);

        do_start(0);
        s = '{256, -256, 0, 257};
        run_stream("bad_var_257", s, 0);

        do_start(0);
        s = '{4, int'(32'h8000_0000)};
        run_stream("bad_var_min", s, 0);

        do_start(0);
        s = '{1, 2, 3, 0, 4, 5, 6, 0, 7, 8, 9, 0, 10, 11, 12, 0, 13};
        run_stream("lit_ovf", s, 0);

        do_start(0);
        s = '{1, 0, 2, 0, 3, 0, 4, 0, 5, 0, 6, 0};
        run_stream("cls_ovf", s, 0);

        do_start(0);
        s = '{1, 0, 2, 0, 3, 0, 4, 0, 5, 0, 6};
        run_stream("cls_ovf_last", s, 0);

        // Backpressure must not change the memory image.
        for (int r = 0; r < 3; r++) begin
            rand_stream(s);
            clear_img();
            do_start(0);
            run_stream("img_nogap", s, 0);
            for (int i = 0; i < 16; i++) img0[i] = img[i];
            clear_img();
            do_start(0);
            run_stream("img_gap", s, 4);
            chk("image_gap_equal", 64'(img == img0), 64'd1);
        end

        for (int r = 0; r < 20; r++) begin
            rand_stream(s);
            do_start(r[0]);
            run_stream("random", s, (r % 3 == 0) ? 0 : 3);
        end

        // Reset in the middle of a load, with a beat on the bus.
        do_start(0);
        begin
            bit t;
            send_beat(32'd1, 1'b0, 0, t);
            send_beat(32'd2, 1'b0, 0, t);
        end
        bus.in_valid = 1'b1;
        bus.in_lit   = 32'd3;
        #2 rst_n = 1'b0;
        #1;
        any_out = |{lit_we, lit_addr, lit_wdata, cls_we, cls_addr, cls_start, cls_len, done, error,
                    err_code, num_clauses, num_lits, max_var, bus.in_ready};
        chk("midload_reset_outputs", 64'(any_out), 64'd0);
        model_clear(0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_status("after_reset");
        bus.in_valid = 1'b0;

        do_start(0);
        s = '{-7, 8, 0, 9, 0};
        s.push_back(-1);
        run_stream("post_reset", s, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/clause_loader.md
# clause_loader

Write-side front end for the mini solver's clause store. Accepts a streamed formula as signed literals (DIMACS order, `0` terminates a clause) over a valid/ready handshake, and writes each literal into literal memory. On each clause terminator it writes one clause-header entry (start, length). It reports clause, literal and max-variable counts on completion and flags range or capacity errors. It sits between the host/DMA formula stream and the clause-store BRAMs (`lit_mem`, `clause_start`, `clause_len`).

## Interface
- `MAX_VARS`, 256, highest legal variable index (|lit| ≤ MAX_VARS)
- `MAX_CLAUSES`, 2560, clause-header capacity
- `MAX_LITS`, 10240, literal-memory capacity

- `clk` in 1: sole clock
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: one-cycle pulse; clears counters and begins a load
- `in_valid` in 1: literal beat valid
- `in_ready` out 1: loader accepts a beat
- `in_lit` in 32: signed literal; `0` means end of clause
- `in_last` in 1: final beat of formula
- `lit_we` out 1: literal write strobe
- `lit_addr` out $clog2(MAX_LITS): literal address
- `lit_wdata` out 32: signed literal
- `cls_we` out 1: clause-header write strobe
- `cls_addr` out $clog2(MAX_CLAUSES): clause index
- `cls_start` out 16: first literal address of the clause
- `cls_len` out 16: literal count of the clause
- `done` out 1: load completed cleanly (level)
- `error` out 1: load aborted (level, sticky)
- `err_code` out 2: 0 NONE, 1 BAD_VAR, 2 LIT_OVF, 3 CLS_OVF
- `num_clauses` out $clog2(MAX_CLAUSES)+1: clauses written
- `num_lits` out $clog2(MAX_LITS)+1: literals written
- `max_var` out $clog2(MAX_VARS)+1: largest |lit| seen

## Operation
- **States:**
  - IDLE: `in_ready`=0.
  - LOAD: `in_ready`=1.
  - DONE: `done`=1.
  - ERROR: `error`=1.
- **State transitions:**
  - `start` in IDLE/DONE/ERROR → LOAD. Clears `lit_ptr`, `cls_ptr`, `cur_start`, `cur_len`, `max_var`, `err_code`, `done`, `error`.
  - `start` in LOAD is ignored.
- **Accepted beat:** `in_valid & in_ready`.
- **Nonzero literal:**
  - abs computed at 33 bits, so −2^31 yields BAD_VAR.
  - abs > MAX_VARS → ERROR, BAD_VAR.
  - Otherwise `lit_ptr` == MAX_LITS → ERROR, LIT_OVF.
  - Otherwise write `lit_mem[lit_ptr]`; `lit_ptr`++, `cur_len`++, `max_var` = max(max_var, abs).
- **Zero literal:**
  - `cur_len` == 0: empty clause, skipped, no header write.
  - Otherwise `cls_ptr` == MAX_CLAUSES → ERROR, CLS_OVF.
  - Otherwise write header {`cur_start`, `cur_len`} at `cls_ptr`; `cls_ptr`++, `cur_start` = `lit_ptr`, `cur_len` = 0.
- **`in_last`:**
  - On a nonzero literal: the literal is written, then the clause is closed implicitly in the same beat. `lit_we` and `cls_we` both pulse; `cls_len` includes that literal.
  - Capacity checks apply to both writes. If either fails, neither write occurs.
  - After processing the last beat: → DONE.
- **Errors:** the offending beat produces no writes. Prior writes remain. `num_*` freeze at last good values.
- **Counters:** `num_clauses` = `cls_ptr`, `num_lits` = `lit_ptr`. 16-bit header fields are zero-extended from pointers.

## Timing
- All outputs registered.
- A beat accepted at edge N produces `lit_we`/`cls_we` plus address and data in cycle N+1, each for exactly one cycle. Throughput is one beat per cycle.
- `in_ready` changes one cycle after a state change. It drops the cycle after `in_last` or an error beat is accepted. No beat is accepted in DONE or ERROR.
- `done`/`error` rise in cycle N+1 after the terminal beat, alongside its final write.
- **Reset values:** state IDLE; every output 0.
- **Reset mid-load:** aborts immediately, no further writes. Memory contents are not cleared.
- `start` coincident with `in_valid` in IDLE: the beat is not accepted; `in_ready` rises the next cycle.

## Structure
- Shared package `sat_mem_pkg`:
  - `loader_state_t` enum
  - `loader_err_t` enum (codes above)
  - localparams for the default MAX_VARS/MAX_CLAUSES/MAX_LITS and derived address widths
  - `lit_abs33` function
- No sub-module. Single FSM with pointer registers and a registered write-port stage.

## Test plan
- **Basic load:** `start`, then beats 1,−2,0,3,0,−1,2,−3,0(last) → lit writes at addr 0..5 with data 1,−2,3,−1,2,−3. Headers (0,2), (2,1), (3,3) at clause addr 0,1,2. `done`=1, `num_clauses`=3, `num_lits`=6, `max_var`=3.
- **Empty clauses and implicit close:** 0,0,5,0,7(last) → headers (0,1) and (1,1) only. Both writes for beat 7 land in the same cycle. `num_clauses`=2.
- **Bad variable:** literal 257 with MAX_VARS=256 → no write, `error`=1, `err_code`=1, `in_ready`=0. Literal 0x80000000 → same result.
- **Capacity:** MAX_LITS=4; stream 5 nonzero literals → 4 writes, then LIT_OVF. MAX_CLAUSES=2, three unit clauses → CLS_OVF on the third `0`.
- **Backpressure and restart:**
  - Random `in_valid` gaps → identical memory image to the gap-free run.
  - `start` after DONE → counters return to 0; the reload writes from addr 0.
  - `rst_n` asserted mid-stream → all outputs 0 asynchronously; no writes after.
